// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Two-requester byte arbiter feeding a single uart_tx.
//                Round-robin on ties, packet locking via the last flag,
//                optional idle gap after each byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int unsigned IDLE_GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       locked
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WAIT_BUSY = 2'd1;
  localparam logic [1:0] c_WAIT_DONE = 2'd2;
  localparam logic [1:0] c_GAP       = 2'd3;

  // Terminal count of the gap counter; unused when no gap is configured.
  localparam int unsigned c_GAP_LAST_INT = (IDLE_GAP_CYCLES > 0) ? (IDLE_GAP_CYCLES - 1) : 0;
  localparam logic [7:0]  c_GAP_LAST     = c_GAP_LAST_INT[7:0];

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_gap_cnt;
  logic       r_last_win1;   // 1: requester 1 was granted most recently
  logic       w_elig0;
  logic       w_elig1;
  logic       w_accept;
  logic       w_win1;
  logic [7:0] w_win_data;
  logic       w_win_last;
  logic       w_enter_idle;

  // Acceptance decision: eligibility under lock, round-robin on ties.
  always_comb begin
    w_elig0    = req0_valid & (~locked | grant[0]);
    w_elig1    = req1_valid & (~locked | grant[1]);
    w_accept   = (r_state == c_IDLE) & ~tx_busy & (w_elig0 | w_elig1);
    w_win1     = w_elig1 & (~w_elig0 | ~r_last_win1);
    w_win_data = w_win1 ? req1_data : req0_data;
    w_win_last = w_win1 ? req1_last : req0_last;
  end

  // Next-state logic for the transmit handshake sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:      if (w_accept) w_next_state = c_WAIT_BUSY;
      c_WAIT_BUSY: if (tx_busy) w_next_state = c_WAIT_DONE;
      c_WAIT_DONE: if (!tx_busy) w_next_state = (IDLE_GAP_CYCLES > 0) ? c_GAP : c_IDLE;
      c_GAP:       if (r_gap_cnt == c_GAP_LAST) w_next_state = c_IDLE;
      default:     w_next_state = c_IDLE;
    endcase
  end

  assign w_enter_idle = (r_state != c_IDLE) && (w_next_state == c_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  // Gap counter runs only in GAP and is zero on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_gap_cnt <= 8'h00;
    else if (r_state == c_GAP) r_gap_cnt <= r_gap_cnt + 8'h01;
    else                       r_gap_cnt <= 8'h00;
  end

  // Registered outputs: one-cycle pulses, held byte, owner and lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      grant       <= 2'b00;
      locked      <= 1'b0;
      r_last_win1 <= 1'b1;
    end else begin
      tx_start   <= w_accept;
      req0_ready <= w_accept & ~w_win1;
      req1_ready <= w_accept & w_win1;
      if (w_accept) begin
        tx_data     <= w_win_data;
        grant       <= w_win1 ? 2'b10 : 2'b01;
        locked      <= ~w_win_last;
        r_last_win1 <= w_win1;
      end else if (w_enter_idle && !locked) begin
        grant <= 2'b00;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a
//                timestamp-based reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       req0_ready, req1_ready, tx_start, locked;
  logic [7:0] tx_data;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.IDLE_GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant), .locked(locked)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a byte is outstanding from acceptance until the uart
  // has been seen busy and then idle; the next acceptance is allowed G+1
  // edges after that idle sample.
  int         cyc = 0;
  int         m_free_at = 0;
  bit         m_outst = 0, m_seen = 0, m_locked = 0, m_rr = 0;
  bit         m_start = 0, m_rdy0 = 0, m_rdy1 = 0;
  logic [1:0] m_grant = 2'b00;
  logic [7:0] m_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step;
    bit v0, v1, w;
    cyc++;
    if (!reset) begin
      m_outst = 0; m_seen = 0; m_locked = 0; m_rr = 0;
      m_start = 0; m_rdy0 = 0; m_rdy1 = 0; m_free_at = 0;
      m_grant = 2'b00; m_data = 8'h00;
    end else begin
      m_start = 0; m_rdy0 = 0; m_rdy1 = 0;
      if (m_outst) begin
        if (!m_seen) m_seen = tx_busy;
        else if (!tx_busy) begin
          m_outst = 0;
          m_free_at = cyc + 1 + G;
        end
      end
      if (!m_outst && cyc >= m_free_at - 1 && !m_locked) m_grant = 2'b00;
      if (!m_outst && cyc >= m_free_at && !tx_busy) begin
        v0 = req0_valid && (!m_locked || m_grant[0]);
        v1 = req1_valid && (!m_locked || m_grant[1]);
        if (v0 || v1) begin
          w        = (v0 && v1) ? m_rr : v1;
          m_data   = w ? req1_data : req0_data;
          m_locked = !(w ? req1_last : req0_last);
          m_grant  = w ? 2'b10 : 2'b01;
          m_rr     = !w;
          m_start  = 1; m_rdy0 = !w; m_rdy1 = w;
          m_outst  = 1; m_seen = 0;
        end
      end
    end
  endtask

  task automatic cmp_cycle;
    if (reset) begin
      chk("cyc_tx_start", tx_start, m_start);
      chk("cyc_req0_ready", req0_ready, m_rdy0);
      chk("cyc_req1_ready", req1_ready, m_rdy1);
      chk("cyc_tx_data", tx_data, m_data);
      chk("cyc_grant", grant, m_grant);
      chk("cyc_locked", locked, m_locked);
    end
  endtask

  // One clock: compare on the falling edge, advance model on the rising
  // edge, return 1 time unit after it so stimulus changes away from edges.
  task automatic tick;
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic busy_pulse(input int len);
    tx_busy = 1'b1;
    repeat (len) tick();
    tx_busy = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("start_seen", tx_start, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_tx_start"}, tx_start, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_req0_ready"}, req0_ready, 0);
    chk({nm, "_req1_ready"}, req1_ready, 0);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_locked"}, locked, 0);
  endtask

  initial begin
    int n, s;
    bit u_pending;
    int u_wait, u_len;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;

    // Single byte from requester 0
    req0_valid = 1; req0_data = 8'hA5; req0_last = 1;
    tick();
    chk("single_start", tx_start, 1);
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    chk("single_data", tx_data, 8'hA5);
    chk("single_grant", grant, 2'b01);
    chk("single_locked", locked, 0);
    req0_valid = 0;
    tick();
    chk("single_start_pulse", tx_start, 0);
    chk("single_ready_pulse", req0_ready, 0);
    busy_pulse(3);
    repeat (G + 2) tick();
    chk("single_grant_release", grant, 2'b00);

    // Tie after reset: requester 0 first, then requester 1
    do_reset();
    req0_valid = 1; req0_data = 8'h11; req0_last = 1;
    req1_valid = 1; req1_data = 8'h22; req1_last = 1;
    tick();
    chk("tie_first_data", tx_data, 8'h11);
    chk("tie_first_grant", grant, 2'b01);
    req0_valid = 0;
    tick();
    busy_pulse(2);
    wait_start(20, n);
    chk("tie_second_data", tx_data, 8'h22);
    chk("tie_second_grant", grant, 2'b10);
    chk("tie_second_ready1", req1_ready, 1);
    req1_valid = 0;
    tick();
    busy_pulse(2);
    repeat (G + 2) tick();

    // Packet lock: three requester-0 bytes precede the waiting requester 1
    do_reset();
    req1_valid = 1; req1_data = 8'h77; req1_last = 1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_data = 8'hB0 + 8'(i); req0_last = (i == 2);
      wait_start(30, n);
      chk("lock_data", tx_data, 8'hB0 + 8'(i));
      chk("lock_grant", grant, 2'b01);
      chk("lock_locked", locked, (i < 2) ? 1 : 0);
      req0_valid = 0;
      tick();
      busy_pulse(2);
      if (i == 0) begin
        s = 0;
        repeat (G + 8) begin
          tick();
          if (tx_start) s++;
        end
        chk("lock_owner_idle_no_start", s, 0);
        chk("lock_held_while_owner_idle", locked, 1);
      end
    end
    wait_start(30, n);
    chk("lock_after_data", tx_data, 8'h77);
    chk("lock_after_grant", grant, 2'b10);
    req1_valid = 0;
    tick();
    busy_pulse(2);
    repeat (G + 2) tick();

    // Gap: continuous requester-1 bytes
    do_reset();
    req1_valid = 1; req1_data = 8'h40; req1_last = 1;
    wait_start(10, n);
    for (int k = 0; k < 3; k++) begin
      req1_data = req1_data + 8'h01;
      tick();
      busy_pulse(2);
      wait_start(30, n);
      chk("gap_cycles", n, G + 2);
      chk("gap_data", tx_data, 8'h41 + 8'(k));
    end
    req1_valid = 0;
    tick();
    busy_pulse(2);
    repeat (G + 2) tick();

    // Reset mid-frame with uart still busy
    req0_valid = 1; req0_data = 8'h3C; req0_last = 1;
    wait_start(10, n);
    tick();
    tx_busy = 1;
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    reset = 1'b1;
    s = 0;
    repeat (6) begin
      tick();
      if (tx_start) s++;
    end
    chk("rst_no_start_while_busy", s, 0);
    tx_busy = 0;
    wait_start(10, n);
    chk("rst_resume_data", tx_data, 8'h3C);
    chk("rst_resume_grant", grant, 2'b01);
    req0_valid = 0;
    tick();
    busy_pulse(2);
    repeat (G + 2) tick();

    // Stall: uart never goes busy
    req0_valid = 1; req0_data = 8'h5A; req0_last = 1;
    wait_start(10, n);
    req0_data = 8'h5B;
    s = 0;
    repeat (20) begin
      tick();
      if (req0_ready || req1_ready || tx_start) s++;
    end
    chk("stall_no_pulse", s, 0);
    busy_pulse(2);
    wait_start(20, n);
    chk("stall_resume_data", tx_data, 8'h5B);
    req0_valid = 0;
    tick();
    busy_pulse(2);
    repeat (G + 2) tick();

    // Randomized traffic with a responsive uart model
    u_pending = 0; u_wait = 0; u_len = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = (c != 1500);
      if (u_pending) begin
        if (u_wait == 0) begin
          tx_busy = 1;
          u_len = $urandom_range(0, 4);
          u_pending = 0;
        end else u_wait--;
      end else if (tx_busy) begin
        if (u_len == 0) tx_busy = 0;
        else u_len--;
      end
      if (tx_start) begin
        u_pending = 1;
        u_wait = $urandom_range(0, 2);
      end
      if (req0_ready) req0_valid = 0;
      if (req1_ready) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1; req0_data = 8'($urandom); req0_last = ($urandom_range(0, 3) == 0);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1; req1_data = 8'($urandom); req1_last = ($urandom_range(0, 3) == 0);
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: IDLE_GAP_CYCLES, default 0, idle clock cycles inserted after each transmitted byte before the next byte may be accepted (0..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a byte; held until req0_ready seen.
REQ-006 req0_data  input  8  requester 0 byte.
REQ-007 req0_last  input  1  byte is the last of requester 0 packet.
REQ-008 req0_ready  output  1  one-cycle pulse: req0_data accepted.
REQ-009 req1_valid / req1_data / req1_last / req1_ready  same widths, directions and meaning for requester 1.
REQ-010 tx_start  output  1  one-cycle pulse to uart_tx: begin frame.
REQ-011 tx_data  output  8  byte to uart_tx; stable from tx_start until next acceptance.
REQ-012 tx_busy  input  1  uart_tx transmitting; goes high after tx_start, low after stop bit.
REQ-013 grant  output  2  one-hot current owner; 2'b00 when no owner.
REQ-014 locked  output  1  high while a packet is in progress (owner fixed).

Function
REQ-015 States SHALL be IDLE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-016 IDLE: acceptance occurs only when tx_busy=0 and at least one eligible requester has valid=1.
REQ-017 Eligibility: if locked=1 only the grant owner is eligible; otherwise both.
REQ-018 Tie (both eligible and valid, unlocked): requester not most recently granted wins (round-robin); single valid requester wins outright.
REQ-019 On acceptance edge: tx_data <= winner data, tx_start <= 1, winner ready <= 1, grant <= winner one-hot, state -> WAIT_BUSY; tx_start and ready deassert on the next edge (exactly one cycle each).
REQ-020 Latency: valid sampled high in IDLE at edge N -> tx_start and ready high during cycle N+1.
REQ-021 Lock: accepted byte with last=0 sets locked=1; accepted byte with last=1 clears locked and grant returns to 2'b00 upon reaching IDLE.
REQ-022 While locked, the owner dropping valid SHALL NOT release the lock; the other requester waits indefinitely.
REQ-023 WAIT_BUSY: remain until tx_busy=1, then -> WAIT_DONE.
REQ-024 WAIT_DONE: remain until tx_busy=0; then -> GAP if IDLE_GAP_CYCLES>0, else -> IDLE.
REQ-025 GAP: 8-bit counter counts IDLE_GAP_CYCLES cycles, then -> IDLE; counter cleared on entry.
REQ-026 valid inputs SHALL be ignored in WAIT_BUSY, WAIT_DONE, GAP (no double acceptance).
REQ-027 Byte throughput: one byte per (tx_busy high time + 2 + IDLE_GAP_CYCLES) cycles minimum.

Reset
REQ-028 Reset assertion SHALL immediately force: state IDLE, tx_start 0, tx_data 8'h00, req0_ready 0, req1_ready 0, grant 2'b00, locked 0, gap counter 0.
REQ-029 Round-robin pointer SHALL reset to "last granted = requester 1" so requester 0 wins the first tie.
REQ-030 Reset mid-frame: uart_tx may remain busy; arbiter SHALL NOT issue tx_start until tx_busy=0 (REQ-016).

Verification
REQ-031 Single byte: req0_valid=1, data 8'hA5, last=1 in IDLE -> tx_start, req0_ready 1 cycle later, tx_data=8'hA5, grant=2'b01, locked=0.
REQ-032 Tie after reset: both valid, last=1, data 8'h11/8'h22 -> tx_data 8'h11 first, then 8'h22 after tx_busy falls; grant 01 then 10.
REQ-033 Packet lock: req0 sends 3 bytes (last=0,0,1) while req1 valid -> all three req0 bytes precede req1 byte; locked=1 until third byte accepted.
REQ-034 Gap: IDLE_GAP_CYCLES=4, continuous req1 bytes -> exactly 4 cycles between tx_busy falling-edge state exit and next tx_start (+1 acceptance cycle).
REQ-035 Reset mid-frame: reset low during WAIT_DONE with tx_busy=1, req0_valid held -> all outputs zero; after release no tx_start until tx_busy=0.
REQ-036 Stall: tx_busy held low 20 cycles after tx_start -> arbiter stays WAIT_BUSY, no further ready pulses.
